// File: rtl/alu_seq.sv
// Registered, handshaked ALU: single-cycle logic/shift/add ops, iterative shift-add MUL and restoring DIV.
// Optional flag outputs (zero/negative/overflow) are enabled by defining ALU_SEQ_FLAGS_EN.
module alu_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
`ifdef ALU_SEQ_FLAGS_EN
  output logic             zero,
  output logic             negative,
  output logic             overflow,
`endif
  output logic             carry_out
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a, op_b, hi, lo;
  logic             op_div;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   sum_w, dif_w;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c;
  logic [WIDTH:0]   mul_sum, div_sh, div_df;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic             it_c;

  assign sum_w = {1'b0, a} + {1'b0, b};
  assign dif_w = {1'b0, a} - {1'b0, b};

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    case (sel)
      4'h0: begin sc_res = sum_w[WIDTH-1:0]; sc_c = sum_w[WIDTH]; end
      4'h1: begin sc_res = dif_w[WIDTH-1:0]; sc_c = dif_w[WIDTH]; end
      4'h4: begin sc_res = {a[WIDTH-2:0], 1'b0}; sc_c = a[WIDTH-1]; end
      4'h5: begin sc_res = {1'b0, a[WIDTH-1:1]}; sc_c = a[0]; end
      4'h6: begin sc_res = {a[WIDTH-2:0], a[WIDTH-1]}; sc_c = a[WIDTH-1]; end
      4'h7: begin sc_res = {a[0], a[WIDTH-1:1]}; sc_c = a[0]; end
      4'h8: sc_res = a & b;
      4'h9: sc_res = a | b;
      4'hA: sc_res = a ^ b;
      4'hB: sc_res = ~(a | b);
      4'hC: sc_res = ~(a & b);
      4'hD: sc_res = ~(a ^ b);
      4'hE: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      4'hF: sc_res = {{(WIDTH-1){1'b0}}, (a == b)};
      default: ;
    endcase
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic sc_ov;
  always_comb begin
    sc_ov = 1'b0;
    if (sel == 4'h0)
      sc_ov = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
    else if (sel == 4'h1)
      sc_ov = (a[WIDTH-1] != b[WIDTH-1]) && (dif_w[WIDTH-1] != a[WIDTH-1]);
  end
`endif

  // hi/lo hold {product high, multiplier->product low} for MUL, {remainder, dividend->quotient} for DIV
  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, op_a} : '0);
  assign div_sh  = {hi, lo[WIDTH-1]};
  assign div_df  = div_sh - {1'b0, op_b};

  always_comb begin
    if (op_div) begin
      if (!div_df[WIDTH]) begin
        hi_n = div_df[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = div_sh[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b0};
      end
      it_c = (op_b == '0);
    end else begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo[WIDTH-1:1]};
      it_c = (hi_n != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_div    <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      zero      <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          op_a     <= a;
          op_b     <= b;
          op_div   <= sel[0];
          in_ready <= 1'b0;
          if (sel == 4'h2 || sel == 4'h3) begin
            hi    <= '0;
            lo    <= sel[0] ? a : b;
            cnt   <= CNT_W'(WIDTH);
            state <= CALC;
          end else begin
            result    <= sc_res;
            carry_out <= sc_c;
`ifdef ALU_SEQ_FLAGS_EN
            zero      <= (sc_res == '0);
            negative  <= sc_res[WIDTH-1];
            overflow  <= sc_ov;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        CALC: begin
          hi  <= hi_n;
          lo  <= lo_n;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            result    <= lo_n;
            carry_out <= it_c;
`ifdef ALU_SEQ_FLAGS_EN
            zero      <= (lo_n == '0);
            negative  <= lo_n[WIDTH-1];
            overflow  <= 1'b0;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=4: per-op results, latency, backpressure, async reset, optional flags.
module tb_alu_seq;
  localparam int W = 4;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, carry_out;
  logic [W-1:0] a = '0, b = '0, result;
  logic [3:0]   sel = '0;
`ifdef ALU_SEQ_FLAGS_EN
  logic         zero, negative, overflow;
`endif

  int checks = 0, failures = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .result(result),
`ifdef ALU_SEQ_FLAGS_EN
    .zero(zero), .negative(negative), .overflow(overflow),
`endif
    .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble the inputs after acceptance, count cycles until out_valid.
  task automatic run_op(input string tg, input logic [3:0] s, input logic [W-1:0] ia, ib,
                        input logic [W-1:0] er, input logic ec, input int el);
    int lat;
    @(negedge clk);
    a = ia; b = ib; sel = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); sel = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      chk({tg, "_busy"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk({tg, "_lat"}, 32'(lat), 32'(el));
    chk({tg, "_res"}, 32'(result), 32'(er));
    chk({tg, "_c"}, 32'(carry_out), 32'(ec));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int seen;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carry", 32'(carry_out), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("add1", 4'h0, 4'h3, 4'h1, 4'h4, 1'b0, 1);
    chk("idle_ready", 32'(in_ready), 32'd1);
    run_op("add2", 4'h0, 4'hF, 4'h1, 4'h0, 1'b1, 1);
    run_op("sub", 4'h1, 4'h3, 4'h5, 4'hE, 1'b1, 1);
    run_op("mul1", 4'h2, 4'h3, 4'h2, 4'h6, 1'b0, 5);
    run_op("mul2", 4'h2, 4'h5, 4'h4, 4'h4, 1'b1, 5);
    run_op("div1", 4'h3, 4'h8, 4'h2, 4'h4, 1'b0, 5);
    run_op("div0", 4'h3, 4'h7, 4'h0, 4'hF, 1'b1, 5);
    run_op("shl", 4'h4, 4'h5, 4'h0, 4'hA, 1'b0, 1);
    run_op("shr", 4'h5, 4'h5, 4'h0, 4'h2, 1'b1, 1);
    run_op("rol", 4'h6, 4'hD, 4'h0, 4'hB, 1'b1, 1);
    run_op("ror", 4'h7, 4'hD, 4'h0, 4'hE, 1'b1, 1);
    run_op("and", 4'h8, 4'hC, 4'hA, 4'h8, 1'b0, 1);
    run_op("or", 4'h9, 4'hC, 4'hA, 4'hE, 1'b0, 1);
    run_op("xor", 4'hA, 4'hC, 4'hA, 4'h6, 1'b0, 1);
    run_op("nor", 4'hB, 4'hC, 4'hA, 4'h1, 1'b0, 1);
    run_op("nand", 4'hC, 4'hC, 4'hA, 4'h7, 1'b0, 1);
    run_op("xnor", 4'hD, 4'hC, 4'hA, 4'h9, 1'b0, 1);
    run_op("lt1", 4'hE, 4'h2, 4'h4, 4'h1, 1'b0, 1);
    run_op("lt0", 4'hE, 4'h4, 4'h2, 4'h0, 1'b0, 1);
    run_op("eq1", 4'hF, 4'h4, 4'h4, 4'h1, 1'b0, 1);
    run_op("eq0", 4'hF, 4'h4, 4'h5, 4'h0, 1'b0, 1);
    chk("hold_idle", 32'(result), 32'd0);

    // Backpressure: result parked in DONE, extra requests ignored
    out_ready = 1'b0;
    @(negedge clk); a = 4'h2; b = 4'h3; sel = 4'h0; in_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); a = 4'hF; b = 4'hF; sel = 4'h1; in_valid = (i != 1);
      @(posedge clk); #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_res", 32'(result), 32'd5);
      chk("bp_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    run_op("bp_next", 4'h1, 4'h3, 4'h5, 4'hE, 1'b1, 1);

    // Async reset during the second CALC cycle of a MUL
    @(negedge clk); a = 4'h3; b = 4'h3; sel = 4'h2; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0; #1;
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_result", 32'(result), 32'd0);
    chk("mrst_carry", 32'(carry_out), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("mrst_no_valid", 32'(seen), 32'd0);
    run_op("post_rst_add", 4'h0, 4'h3, 4'h1, 4'h4, 1'b0, 1);

`ifdef ALU_SEQ_FLAGS_EN
    run_op("fl_add", 4'h0, 4'h7, 4'h1, 4'h8, 1'b0, 1);
    chk("fl_ov", 32'(overflow), 32'd1);
    chk("fl_neg", 32'(negative), 32'd1);
    chk("fl_zero", 32'(zero), 32'd0);
    run_op("fl_mul", 4'h2, 4'h0, 4'h5, 4'h0, 1'b0, 5);
    chk("fl_zero_mul", 32'(zero), 32'd1);
    chk("fl_ov_mul", 32'(overflow), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
